// File: rtl/mmu_bitmap_alloc_if.sv
// Request/response bundle of the bitmap page allocator.
// Handshake: a *_submit or *_pop is a single-cycle strobe sampled on the rising
// clock edge. A submit is accepted only while the matching *_fifo_full is low.
// A pop is honoured only while the matching *_fifo_not_empty is high, and the
// popped fields appear on the response outputs on the following cycle.
interface mmu_bitmap_alloc_if #(
    parameter int ID_WIDTH  = 13,
    parameter int IDX_WIDTH = 12,
    parameter int CNT_WIDTH = 4
);
    logic                 alloc_req_submit;
    logic [ID_WIDTH-1:0]  alloc_req_id;
    logic [CNT_WIDTH-1:0] alloc_req_page_count;
    logic                 free_req_submit;
    logic [ID_WIDTH-1:0]  free_req_id;
    logic [IDX_WIDTH-1:0] free_req_page_idx;
    logic [CNT_WIDTH-1:0] free_req_page_count;
    logic                 alloc_rsp_pop;
    logic                 free_rsp_pop;
    logic [ID_WIDTH-1:0]  alloc_rsp_id;
    logic [IDX_WIDTH-1:0] alloc_rsp_page_idx;
    logic                 alloc_rsp_fail;
    logic [2:0]           alloc_rsp_fail_reason;
    logic [ID_WIDTH-1:0]  free_rsp_id;
    logic                 free_rsp_fail;
    logic [2:0]           free_rsp_fail_reason;
    logic                 alloc_req_fifo_full;
    logic                 free_req_fifo_full;
    logic                 alloc_rsp_fifo_not_empty;
    logic                 free_rsp_fifo_not_empty;
    logic [IDX_WIDTH:0]   free_page_count;
    logic                 busy;
    logic [2:0]           state_dbg;

    modport master (
        output alloc_req_submit, alloc_req_id, alloc_req_page_count,
               free_req_submit, free_req_id, free_req_page_idx, free_req_page_count,
               alloc_rsp_pop, free_rsp_pop,
        input  alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
               free_rsp_id, free_rsp_fail, free_rsp_fail_reason,
               alloc_req_fifo_full, free_req_fifo_full,
               alloc_rsp_fifo_not_empty, free_rsp_fifo_not_empty,
               free_page_count, busy, state_dbg
    );

    modport slave (
        input  alloc_req_submit, alloc_req_id, alloc_req_page_count,
               free_req_submit, free_req_id, free_req_page_idx, free_req_page_count,
               alloc_rsp_pop, free_rsp_pop,
        output alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
               free_rsp_id, free_rsp_fail, free_rsp_fail_reason,
               alloc_req_fifo_full, free_req_fifo_full,
               alloc_rsp_fifo_not_empty, free_rsp_fifo_not_empty,
               free_page_count, busy, state_dbg
    );
endinterface

// File: rtl/mmu_bitmap_alloc.sv
// Bitmap page allocator: power-of-two, naturally aligned, lowest-address
// first-fit allocation plus checked frees, fed and drained through FIFOs.

// Synchronous FIFO; push while full and pop while empty are ignored.
module mmu_bitmap_alloc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             not_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign not_empty = (count != '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && not_empty;
    assign dout      = mem[rd_ptr];

    // Storage array; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module mmu_bitmap_alloc #(
    parameter int NUM_PAGES  = 4096,
    parameter int MAX_PAGES  = 8,
    parameter int ID_WIDTH   = 13,
    parameter int IDX_WIDTH  = 12,
    parameter int CNT_WIDTH  = 4,
    parameter int FIFO_DEPTH = 16
) (
    input logic               clk,
    input logic               rst,
    mmu_bitmap_alloc_if.slave bus
);
    localparam int LOG_MAX    = $clog2(MAX_PAGES);
    localparam int GRP_W      = IDX_WIDTH - LOG_MAX;
    localparam int NUM_GROUPS = NUM_PAGES / MAX_PAGES;
    localparam int AREQ_W     = ID_WIDTH + CNT_WIDTH;
    localparam int FREQ_W     = ID_WIDTH + IDX_WIDTH + CNT_WIDTH;
    localparam int ARSP_W     = ID_WIDTH + IDX_WIDTH + 4;
    localparam int FRSP_W     = ID_WIDTH + 4;

    localparam logic [2:0] FAIL_NONE      = 3'd0;
    localparam logic [2:0] FAIL_BAD_SIZE  = 3'd1;
    localparam logic [2:0] FAIL_NO_SPACE  = 3'd2;
    localparam logic [2:0] FAIL_BAD_IDX   = 3'd3;
    localparam logic [2:0] FAIL_NOT_ALLOC = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_FREE_CHK, S_ALLOC_CHK, S_SCAN, S_RESP
    } state_t;

    state_t               state;
    logic [NUM_PAGES-1:0] bitmap;
    logic [IDX_WIDTH:0]   free_count;
    logic [ID_WIDTH-1:0]  cur_id;
    logic [IDX_WIDTH-1:0] cur_idx;
    logic [CNT_WIDTH-1:0] cur_cnt;
    logic                 cur_is_free;
    logic                 res_fail;
    logic [2:0]           res_reason;
    logic [IDX_WIDTH-1:0] res_idx;
    logic [GRP_W-1:0]     group;

    logic [AREQ_W-1:0] areq_dout;
    logic [FREQ_W-1:0] freq_dout;
    logic [ARSP_W-1:0] arsp_dout;
    logic [FRSP_W-1:0] frsp_dout;
    logic areq_ne, freq_ne, arsp_ne, frsp_ne, arsp_full, frsp_full;
    logic areq_pop, freq_pop, arsp_push, frsp_push;

    // Smallest power of two not below c (c assumed within 1..MAX_PAGES).
    function automatic logic [CNT_WIDTH-1:0] round_size(input logic [CNT_WIDTH-1:0] c);
        logic [CNT_WIDTH-1:0] r;
        r = '0;
        for (int k = LOG_MAX; k >= 0; k--) begin
            if (int'(c) <= (1 << k)) r = CNT_WIDTH'(1 << k);
        end
        return r;
    endfunction

    mmu_bitmap_alloc_fifo #(.WIDTH(AREQ_W), .DEPTH(FIFO_DEPTH)) u_areq (
        .clk(clk), .rst(rst), .push(bus.alloc_req_submit),
        .din({bus.alloc_req_id, bus.alloc_req_page_count}),
        .pop(areq_pop), .dout(areq_dout), .full(bus.alloc_req_fifo_full), .not_empty(areq_ne));
    mmu_bitmap_alloc_fifo #(.WIDTH(FREQ_W), .DEPTH(FIFO_DEPTH)) u_freq (
        .clk(clk), .rst(rst), .push(bus.free_req_submit),
        .din({bus.free_req_id, bus.free_req_page_idx, bus.free_req_page_count}),
        .pop(freq_pop), .dout(freq_dout), .full(bus.free_req_fifo_full), .not_empty(freq_ne));
    mmu_bitmap_alloc_fifo #(.WIDTH(ARSP_W), .DEPTH(FIFO_DEPTH)) u_arsp (
        .clk(clk), .rst(rst), .push(arsp_push), .din({cur_id, res_idx, res_fail, res_reason}),
        .pop(bus.alloc_rsp_pop), .dout(arsp_dout), .full(arsp_full), .not_empty(arsp_ne));
    mmu_bitmap_alloc_fifo #(.WIDTH(FRSP_W), .DEPTH(FIFO_DEPTH)) u_frsp (
        .clk(clk), .rst(rst), .push(frsp_push), .din({cur_id, res_fail, res_reason}),
        .pop(bus.free_rsp_pop), .dout(frsp_dout), .full(frsp_full), .not_empty(frsp_ne));

    // Free requests win over allocs; responses leave only when their FIFO has room.
    assign freq_pop  = (state == S_IDLE) && freq_ne;
    assign areq_pop  = (state == S_IDLE) && !freq_ne && areq_ne;
    assign arsp_push = (state == S_RESP) && !cur_is_free && !arsp_full;
    assign frsp_push = (state == S_RESP) && cur_is_free && !frsp_full;

    logic [CNT_WIDTH-1:0] cur_size;
    logic                 size_bad;
    logic                 idx_bad;
    logic [GRP_W-1:0]     free_grp;
    logic [LOG_MAX-1:0]   free_off;
    logic [MAX_PAGES-1:0] free_mask;
    logic [MAX_PAGES-1:0] free_bits;
    logic                 not_alloc;
    logic [MAX_PAGES-1:0] size_mask;
    logic [MAX_PAGES-1:0] scan_bits;
    logic                 scan_hit;
    logic [LOG_MAX-1:0]   hit_off;
    logic [MAX_PAGES-1:0] hit_mask;

    assign cur_size = round_size(cur_cnt);
    assign size_bad = (cur_cnt == '0) || (int'(cur_cnt) > MAX_PAGES);
    assign idx_bad  = (int'(cur_idx) + int'(cur_size) > NUM_PAGES) ||
                      ((cur_idx & (IDX_WIDTH'(cur_size) - IDX_WIDTH'(1))) != '0);
    assign free_grp = cur_idx[IDX_WIDTH-1:LOG_MAX];
    assign free_off = cur_idx[LOG_MAX-1:0];

    // Range masks and the in-group search; a valid aligned run never crosses a group.
    always_comb begin
        free_mask = '0;
        size_mask = '0;
        for (int i = 0; i < MAX_PAGES; i++) begin
            free_mask[i] = (i >= int'(free_off)) && (i < int'(free_off) + int'(cur_size));
            size_mask[i] = (i < int'(cur_size));
        end
        free_bits = bitmap[free_grp*MAX_PAGES +: MAX_PAGES];
        not_alloc = ((free_bits & free_mask) != free_mask);
        scan_bits = bitmap[group*MAX_PAGES +: MAX_PAGES];
        scan_hit  = 1'b0;
        hit_off   = '0;
        // Walk downwards so the lowest fitting offset is the one left standing.
        for (int o = MAX_PAGES - 1; o >= 0; o--) begin
            if (((o & (int'(cur_size) - 1)) == 0) && (o + int'(cur_size) <= MAX_PAGES) &&
                (((scan_bits >> o) & size_mask) == '0)) begin
                scan_hit = 1'b1;
                hit_off  = LOG_MAX'(o);
            end
        end
        hit_mask = size_mask << hit_off;
    end

    // Request engine: one request at a time, bitmap and free count updated in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            bitmap      <= '0;
            free_count  <= (IDX_WIDTH+1)'(NUM_PAGES);
            cur_id      <= '0;
            cur_idx     <= '0;
            cur_cnt     <= '0;
            cur_is_free <= 1'b0;
            res_fail    <= 1'b0;
            res_reason  <= FAIL_NONE;
            res_idx     <= '0;
            group       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (freq_ne) begin
                        {cur_id, cur_idx, cur_cnt} <= freq_dout;
                        cur_is_free <= 1'b1;
                        state       <= S_FREE_CHK;
                    end else if (areq_ne) begin
                        {cur_id, cur_cnt} <= areq_dout;
                        cur_idx     <= '0;
                        cur_is_free <= 1'b0;
                        state       <= S_ALLOC_CHK;
                    end
                end
                S_FREE_CHK: begin
                    res_idx  <= '0;
                    res_fail <= 1'b1;
                    state    <= S_RESP;
                    if (size_bad)       res_reason <= FAIL_BAD_SIZE;
                    else if (idx_bad)   res_reason <= FAIL_BAD_IDX;
                    else if (not_alloc) res_reason <= FAIL_NOT_ALLOC;
                    else begin
                        bitmap[free_grp*MAX_PAGES +: MAX_PAGES] <= free_bits & ~free_mask;
                        free_count <= free_count + (IDX_WIDTH+1)'(cur_size);
                        res_fail   <= 1'b0;
                        res_reason <= FAIL_NONE;
                    end
                end
                S_ALLOC_CHK: begin
                    res_idx <= '0;
                    if (size_bad) begin
                        res_fail   <= 1'b1;
                        res_reason <= FAIL_BAD_SIZE;
                        state      <= S_RESP;
                    end else if (free_count < (IDX_WIDTH+1)'(cur_size)) begin
                        res_fail   <= 1'b1;
                        res_reason <= FAIL_NO_SPACE;
                        state      <= S_RESP;
                    end else begin
                        group <= '0;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (scan_hit) begin
                        bitmap[group*MAX_PAGES +: MAX_PAGES] <= scan_bits | hit_mask;
                        free_count <= free_count - (IDX_WIDTH+1)'(cur_size);
                        res_idx    <= {group, hit_off};
                        res_fail   <= 1'b0;
                        res_reason <= FAIL_NONE;
                        state      <= S_RESP;
                    end else if (group == GRP_W'(NUM_GROUPS - 1)) begin
                        res_fail   <= 1'b1;
                        res_reason <= FAIL_NO_SPACE;
                        state      <= S_RESP;
                    end else begin
                        group <= group + 1'b1;
                    end
                end
                S_RESP: begin
                    if (cur_is_free ? !frsp_full : !arsp_full) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Response output registers, loaded from the FIFO head on an effective pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.alloc_rsp_id          <= '0;
            bus.alloc_rsp_page_idx    <= '0;
            bus.alloc_rsp_fail        <= 1'b0;
            bus.alloc_rsp_fail_reason <= '0;
            bus.free_rsp_id           <= '0;
            bus.free_rsp_fail         <= 1'b0;
            bus.free_rsp_fail_reason  <= '0;
        end else begin
            if (bus.alloc_rsp_pop && arsp_ne)
                {bus.alloc_rsp_id, bus.alloc_rsp_page_idx, bus.alloc_rsp_fail,
                 bus.alloc_rsp_fail_reason} <= arsp_dout;
            if (bus.free_rsp_pop && frsp_ne)
                {bus.free_rsp_id, bus.free_rsp_fail, bus.free_rsp_fail_reason} <= frsp_dout;
        end
    end

    assign bus.alloc_rsp_fifo_not_empty = arsp_ne;
    assign bus.free_rsp_fifo_not_empty  = frsp_ne;
    assign bus.free_page_count          = free_count;
    assign bus.busy                     = (state != S_IDLE);
    assign bus.state_dbg                = state;
endmodule

// File: tb/tb_mmu_bitmap_alloc.sv
// Bench for mmu_bitmap_alloc. Uses a 1024-page instance so that whole-array
// scans (exhaustion, fragmentation) stay short; expected values derive from it.
module tb_mmu_bitmap_alloc;
    localparam int NUM_PAGES  = 1024;
    localparam int MAX_PAGES  = 8;
    localparam int ID_WIDTH   = 13;
    localparam int IDX_WIDTH  = 10;
    localparam int CNT_WIDTH  = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int NUM_GROUPS = NUM_PAGES / MAX_PAGES;
    localparam int AW = ID_WIDTH + IDX_WIDTH + 4;
    localparam int FW = ID_WIDTH + 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mmu_bitmap_alloc_if #(.ID_WIDTH(ID_WIDTH), .IDX_WIDTH(IDX_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    mmu_bitmap_alloc #(
        .NUM_PAGES(NUM_PAGES), .MAX_PAGES(MAX_PAGES), .ID_WIDTH(ID_WIDTH),
        .IDX_WIDTH(IDX_WIDTH), .CNT_WIDTH(CNT_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- scoreboard state ----------------
    logic [AW-1:0] exp_alloc_q[$];
    logic [FW-1:0] exp_free_q[$];
    int  checks;
    int  errors;
    bit  pop_en;
    bit  a_pend;
    bit  f_pend;

    // ---------------- reference model ----------------
    bit ref_map[NUM_PAGES];
    int ref_free;
    int live_idx[$];
    int live_size[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic int round_up(input int c);
        int p;
        p = 1;
        while (p < c) p = p * 2;
        return p;
    endfunction

    function automatic bit range_is(input int a, input int s, input bit v);
        for (int k = 0; k < s; k++) if (ref_map[a + k] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_alloc(input int id, input int cnt);
        int s;
        int found;
        logic fail;
        logic [2:0] rsn;
        found = -1;
        fail = 1'b0;
        rsn = 3'd0;
        if (cnt == 0 || cnt > MAX_PAGES) begin
            fail = 1'b1; rsn = 3'd1;
        end else begin
            s = round_up(cnt);
            if (ref_free >= s)
                for (int a = 0; a + s <= NUM_PAGES && found < 0; a += s)
                    if (range_is(a, s, 1'b0)) found = a;
            if (found < 0) begin
                fail = 1'b1; rsn = 3'd2;
            end else begin
                for (int k = 0; k < s; k++) ref_map[found + k] = 1'b1;
                ref_free -= s;
                live_idx.push_back(found);
                live_size.push_back(s);
            end
        end
        exp_alloc_q.push_back({ID_WIDTH'(id), IDX_WIDTH'(fail ? 0 : found), fail, rsn});
    endtask

    task automatic model_free(input int id, input int idx, input int cnt);
        int s;
        logic fail;
        logic [2:0] rsn;
        fail = 1'b1;
        rsn = 3'd0;
        if (cnt == 0 || cnt > MAX_PAGES) rsn = 3'd1;
        else begin
            s = round_up(cnt);
            if (idx + s > NUM_PAGES || idx % s != 0) rsn = 3'd3;
            else if (!range_is(idx, s, 1'b1))     rsn = 3'd4;
            else begin
                fail = 1'b0;
                for (int k = 0; k < s; k++) ref_map[idx + k] = 1'b0;
                ref_free += s;
                for (int j = 0; j < live_idx.size(); j++)
                    if (live_idx[j] == idx && live_size[j] == s) begin
                        live_idx.delete(j);
                        live_size.delete(j);
                        break;
                    end
            end
        end
        exp_free_q.push_back({ID_WIDTH'(id), fail, rsn});
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alloc(input int id, input int cnt);
        bus.alloc_req_id         = ID_WIDTH'(id);
        bus.alloc_req_page_count = CNT_WIDTH'(cnt);
        bus.alloc_req_submit     = 1'b1;
        tick();
        bus.alloc_req_submit     = 1'b0;
    endtask

    task automatic drive_free(input int id, input int idx, input int cnt);
        bus.free_req_id         = ID_WIDTH'(id);
        bus.free_req_page_idx   = IDX_WIDTH'(idx);
        bus.free_req_page_count = CNT_WIDTH'(cnt);
        bus.free_req_submit     = 1'b1;
        tick();
        bus.free_req_submit     = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        tick();
        while (bus.busy && n < 5000) begin tick(); n++; end
        if (bus.busy) begin
            checks++; errors++;
            $display("FAIL %s_timeout: busy=1 after %0d cycles, required 0", name, n);
        end
    endtask

    task automatic do_alloc(input int id, input int cnt);
        model_alloc(id, cnt);
        drive_alloc(id, cnt);
        wait_idle("alloc");
    endtask

    task automatic do_free(input int id, input int idx, input int cnt);
        model_free(id, idx, cnt);
        drive_free(id, idx, cnt);
        wait_idle("free");
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_alloc_q.size() != 0 || exp_free_q.size() != 0) && n < budget) begin tick(); n++; end
        repeat (2) tick();
        if (exp_alloc_q.size() != 0 || exp_free_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d alloc and %0d free responses outstanding, required 0",
                     exp_alloc_q.size(), exp_free_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < NUM_PAGES; k++) ref_map[k] = 1'b0;
        ref_free = NUM_PAGES;
        exp_alloc_q.delete();
        exp_free_q.delete();
        live_idx.delete();
        live_size.delete();
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [AW-1:0] ea;
        logic [FW-1:0] ef;
        bus.alloc_rsp_pop = 1'b0;
        bus.free_rsp_pop  = 1'b0;
        forever begin
            tick();
            if (a_pend) begin
                if (exp_alloc_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL alloc_rsp_unexpected: got id %0d, required no response", bus.alloc_rsp_id);
                end else begin
                    ea = exp_alloc_q.pop_front();
                    check("alloc_rsp{id,idx,fail,reason}",
                          {bus.alloc_rsp_id, bus.alloc_rsp_page_idx, bus.alloc_rsp_fail,
                           bus.alloc_rsp_fail_reason}, ea);
                end
                a_pend = 1'b0;
            end
            if (f_pend) begin
                if (exp_free_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL free_rsp_unexpected: got id %0d, required no response", bus.free_rsp_id);
                end else begin
                    ef = exp_free_q.pop_front();
                    check("free_rsp{id,fail,reason}",
                          {bus.free_rsp_id, bus.free_rsp_fail, bus.free_rsp_fail_reason}, ef);
                end
                f_pend = 1'b0;
            end
            if (pop_en && !rst && bus.alloc_rsp_fifo_not_empty) begin
                bus.alloc_rsp_pop = 1'b1; a_pend = 1'b1;
            end else bus.alloc_rsp_pop = 1'b0;
            if (pop_en && !rst && bus.free_rsp_fifo_not_empty) begin
                bus.free_rsp_pop = 1'b1; f_pend = 1'b1;
            end else bus.free_rsp_pop = 1'b0;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int busy_cyc;
        int n;
        int r;
        int k;
        checks = 0;
        errors = 0;
        a_pend = 1'b0;
        f_pend = 1'b0;
        pop_en = 1'b1;
        rst = 1'b1;
        bus.alloc_req_submit = 1'b0;
        bus.alloc_req_id = '0;
        bus.alloc_req_page_count = '0;
        bus.free_req_submit = 1'b0;
        bus.free_req_id = '0;
        bus.free_req_page_idx = '0;
        bus.free_req_page_count = '0;
        do_reset();

        // Reset state.
        check("rst_free_page_count", bus.free_page_count, NUM_PAGES);
        check("rst_busy", bus.busy, 0);
        check("rst_alloc_req_full", bus.alloc_req_fifo_full, 0);
        check("rst_free_req_full", bus.free_req_fifo_full, 0);
        check("rst_alloc_rsp_ne", bus.alloc_rsp_fifo_not_empty, 0);
        check("rst_free_rsp_ne", bus.free_rsp_fifo_not_empty, 0);
        check("rst_alloc_rsp_fields", {bus.alloc_rsp_id, bus.alloc_rsp_page_idx,
              bus.alloc_rsp_fail, bus.alloc_rsp_fail_reason}, 0);
        check("rst_free_rsp_fields", {bus.free_rsp_id, bus.free_rsp_fail, bus.free_rsp_fail_reason}, 0);

        // Basic first-fit with rounding: 1 page at 0, then 3 -> 4 pages at 4.
        do_alloc(1, 1);
        do_alloc(2, 3);
        check("t1_free_page_count", bus.free_page_count, NUM_PAGES - 5);

        // Bad sizes leave the count untouched.
        do_alloc(3, 0);
        do_alloc(4, 9);
        check("t2_free_page_count", bus.free_page_count, NUM_PAGES - 5);
        wait_drain(200);

        // Free checks: good free, double free, misaligned free.
        do_reset();
        do_alloc(5, 8);
        do_free(6, 0, 8);
        do_free(7, 0, 8);
        do_free(8, 2, 4);
        check("t3_free_page_count", bus.free_page_count, NUM_PAGES);
        wait_drain(200);

        // Exhaust, then reuse a single freed page.
        do_reset();
        for (int i = 0; i < NUM_GROUPS; i++) do_alloc(100 + i, 8);
        check("t4_full_count", bus.free_page_count, 0);
        do_alloc(20, 1);
        do_free(21, 8, 1);
        do_alloc(22, 1);
        check("t4_free_page_count", bus.free_page_count, ref_free);

        // Fragment group 0 and time a full fruitless scan.
        for (int p = 0; p < MAX_PAGES; p += 2) do_free(30 + p, p, 1);
        model_alloc(40, 2);
        drive_alloc(40, 2);
        busy_cyc = 0;
        n = 0;
        tick();
        while (bus.busy && n < 5000) begin busy_cyc++; tick(); n++; end
        check("t5_scan_busy_cycles", busy_cyc, NUM_GROUPS + 2);
        check("t5_free_page_count", bus.free_page_count, MAX_PAGES / 2);
        wait_drain(200);

        // Response back-pressure and request FIFO overflow.
        do_reset();
        pop_en = 1'b0;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            model_alloc(200 + i, 1);
            drive_alloc(200 + i, 1);
        end
        repeat (150) tick();
        check("t6_rsp_not_empty", bus.alloc_rsp_fifo_not_empty, 1);
        check("t6_stall_busy", bus.busy, 1);
        check("t6_stall_state", bus.state_dbg, 4);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            model_alloc(300 + i, 1);
            drive_alloc(300 + i, 1);
        end
        check("t6_req_full", bus.alloc_req_fifo_full, 1);
        drive_alloc(999, 1);
        check("t6_req_full_after_drop", bus.alloc_req_fifo_full, 1);
        pop_en = 1'b1;
        wait_drain(2000);
        check("t6_idle", bus.busy, 0);
        check("t6_free_page_count", bus.free_page_count, NUM_PAGES - 2 * FIFO_DEPTH - 1);
        check("t6_rsp_empty", bus.alloc_rsp_fifo_not_empty, 0);

        // Randomised mix against the reference model.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                do_alloc(1000 + i, int'($urandom_range(0, 9)));
            end else if (r < 85 && live_idx.size() != 0) begin
                k = int'($urandom_range(0, live_idx.size() - 1));
                do_free(1000 + i, live_idx[k], live_size[k]);
            end else begin
                do_free(1000 + i, int'($urandom_range(0, NUM_PAGES - 1)), int'($urandom_range(0, 9)));
            end
            check("rand_free_page_count", bus.free_page_count, ref_free);
        end
        wait_drain(500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
